// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: decoder opcodes,
// default latencies and the FSM state type.
package mdu_defs;

    localparam logic [2:0] MDU_MULT  = 3'b011;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b101;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b001;
    localparam logic [2:0] MDU_MTLO  = 3'b000;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_t;

endpackage

// File: rtl/md_unit_calc.sv
// Combinational 64-bit mult/div result. res_wr=0 means HI/LO must be left
// untouched (divide by zero or a non-arithmetic opcode).
module md_calc
    import mdu_defs::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        res_wr
);

    logic               div_ovf;
    logic [31:0]        dvsr;
    logic signed [63:0] sprod;
    logic [63:0]        uprod;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic [31:0]        uquot;
    logic [31:0]        urem;

    always_comb begin
        div_ovf = (a == 32'h8000_0000) && (b == '1);
        // Dividing by 1 instead of 0 or -1 keeps the divider defined; for the
        // overflow case it also yields exactly quotient 0x80000000, remainder 0.
        dvsr  = ((b == '0) || div_ovf) ? 32'd1 : b;
        sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        uprod = {32'b0, a} * {32'b0, b};
        squot = $signed(a) / $signed(dvsr);
        srem  = $signed(a) % $signed(dvsr);
        uquot = a / dvsr;
        urem  = a % dvsr;

        res    = '0;
        res_wr = 1'b0;
        case (op)
            MDU_MULT: begin
                res    = sprod;
                res_wr = 1'b1;
            end
            MDU_MULTU: begin
                res    = uprod;
                res_wr = 1'b1;
            end
            MDU_DIV: begin
                res    = {srem, squot};
                res_wr = (b != '0);
            end
            MDU_DIVU: begin
                res    = {urem, uquot};
                res_wr = (b != '0);
            end
            default: begin
                res    = '0;
                res_wr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div with HI/LO commit at
// the end of the run, single-cycle mthi/mtlo, busy/start for the hazard unit.
module md_unit
    import mdu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDU_op,
    input  logic        md,
    input  logic        mt,
    input  logic        flush,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mdu_state_t  state;
    mdu_state_t  state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;
    logic [63:0] calc_res;
    logic        calc_wr;
    logic        done;
    logic        mt_write;

    md_calc u_calc (
        .op     (MDU_op),
        .a      (A),
        .b      (B),
        .res    (calc_res),
        .res_wr (calc_wr)
    );

    always_comb begin
        busy     = (state == ST_RUN);
        start    = md & ~flush & ~busy;
        mt_write = mt & ~flush & ~busy;
        done     = (state == ST_RUN) && (cnt == 4'd1);
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                    cnt_next   = MDU_op[2] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end
            end
            ST_RUN: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Result is captured at start so the operands need not be held stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_hi <= '0;
            res_lo <= '0;
            res_wr <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            if (start) begin
                res_hi <= calc_res[63:32];
                res_lo <= calc_res[31:0];
                res_wr <= calc_wr;
            end
            if (done) begin
                if (res_wr) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end else if (mt_write) begin
                if (MDU_op[0]) begin
                    HI <= A;
                end else begin
                    LO <= A;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Randomized scoreboard bench for md_unit: stimulus pushes expected HI/LO and
// busy latency, a negedge monitor pops on each busy fall or snapshot request.
module tb_md_unit;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDU_op;
    logic        md;
    logic        mt;
    logic        flush;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .A      (A),
        .B      (B),
        .MDU_op (MDU_op),
        .md     (md),
        .mt     (mt),
        .flush  (flush),
        .start  (start),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    typedef struct {
        bit          is_snap;
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic        busy_e;
        logic        start_e;
    } want_t;

    want_t       want_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;
    logic        snap_req = 1'b0;
    bit          mon_en = 1'b0;
    logic        mon_prev_busy = 1'b0;
    int          mon_run = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Architectural effect of one instruction on HI/LO.
    function automatic void ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        logic [63:0]     w;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            MDU_MULT: begin
                w = sa * sb;
                ref_hi = w[63:32];
                ref_lo = w[31:0];
            end
            MDU_MULTU: begin
                w = {32'b0, a} * {32'b0, b};
                ref_hi = w[63:32];
                ref_lo = w[31:0];
            end
            MDU_DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                w = q;
                ref_lo = w[31:0];
                w = r;
                ref_hi = w[31:0];
            end
            MDU_DIVU: if (b != 0) begin
                ref_lo = a / b;
                ref_hi = a % b;
            end
            default: ;
        endcase
    endfunction

    initial begin
        want_t w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (busy === 1'b1) begin
                    mon_run++;
                end else if (mon_prev_busy === 1'b1) begin
                    if (want_q.size() == 0 || want_q[0].is_snap) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_done: busy fell after %0d cycles, no op expected", mon_run);
                    end else begin
                        w = want_q.pop_front();
                        chk({w.name, "_lat"}, 32'(mon_run), 32'(w.lat));
                        chk({w.name, "_hi"}, HI, w.hi);
                        chk({w.name, "_lo"}, LO, w.lo);
                    end
                    mon_run = 0;
                end
                mon_prev_busy = busy;
                if (snap_req === 1'b1) begin
                    if (want_q.size() == 0 || !want_q[0].is_snap) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL snap_order: snapshot requested, got none, required snapshot entry");
                    end else begin
                        w = want_q.pop_front();
                        chk({w.name, "_busy"}, 32'(busy), 32'(w.busy_e));
                        chk({w.name, "_start"}, 32'(start), 32'(w.start_e));
                        chk({w.name, "_hi"}, HI, w.hi);
                        chk({w.name, "_lo"}, LO, w.lo);
                    end
                end
            end
        end
    end

    task automatic snap(input string name, input logic start_e);
        want_t w;
        w.is_snap = 1'b1;
        w.name    = name;
        w.hi      = ref_hi;
        w.lo      = ref_lo;
        w.lat     = 0;
        w.busy_e  = 1'b0;
        w.start_e = start_e;
        want_q.push_back(w);
        snap_req = 1'b1;
        @(posedge clk); #1;
        snap_req = 1'b0;
    endtask

    task automatic wait_idle(input bit noisy, input int flush_at);
        int k = 0;
        while (busy === 1'b1 && k < 40) begin
            if (noisy) begin
                md     = ($urandom % 3 == 0);
                mt     = ($urandom % 3 == 0);
                flush  = ($urandom % 2 == 0);
                MDU_op = 3'($urandom);
                A      = $urandom;
                B      = $urandom;
            end
            if (k == flush_at) begin
                md    = 1'b1;
                mt    = 1'b1;
                flush = 1'b1;
            end
            @(posedge clk); #1;
            md    = 1'b0;
            mt    = 1'b0;
            flush = 1'b0;
            k++;
        end
        chk("wait_idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name, input bit noisy, input int flush_at);
        want_t w;
        ref_exec(op, a, b);
        w.is_snap = 1'b0;
        w.name    = name;
        w.hi      = ref_hi;
        w.lo      = ref_lo;
        w.lat     = op[2] ? 10 : 5;
        w.busy_e  = 1'b0;
        w.start_e = 1'b0;
        want_q.push_back(w);
        md = 1'b1; mt = 1'b0; flush = 1'b0;
        MDU_op = op; A = a; B = b;
        @(posedge clk); #1;
        md = 1'b0;
        A = $urandom;
        B = $urandom;
        wait_idle(noisy, flush_at);
    endtask

    task automatic do_mt(input bit to_hi, input logic [31:0] v, input bit fl);
        mt = 1'b1;
        MDU_op = to_hi ? MDU_MTHI : MDU_MTLO;
        A = v;
        flush = fl;
        @(posedge clk); #1;
        mt = 1'b0;
        flush = 1'b0;
        if (!fl) begin
            if (to_hi) ref_hi = v;
            else       ref_lo = v;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        want_t       w;
        logic [2:0]  ops [4];
        logic [2:0]  op;
        logic [31:0] ra, rb;
        int          sel;

        ops[0] = MDU_MULT; ops[1] = MDU_MULTU; ops[2] = MDU_DIV; ops[3] = MDU_DIVU;
        reset = 1'b1; md = 1'b0; mt = 1'b0; flush = 1'b0;
        MDU_op = '0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        snap("reset", 1'b0);

        do_md(MDU_MULT, 32'hFFFF_FFFE, 32'd3, "mult_neg", 1'b0, -1);
        do_md(MDU_DIVU, 32'd7, 32'd2, "divu_7_2", 1'b0, -1);
        do_md(MDU_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0, -1);

        do_mt(1'b1, 32'h1234, 1'b0);
        do_mt(1'b0, 32'h5678, 1'b0);
        snap("mt_pair", 1'b0);
        do_md(MDU_DIV, $urandom, 32'd0, "div_by_zero", 1'b0, -1);

        md = 1'b1; flush = 1'b1; MDU_op = MDU_MULT; A = 32'd5; B = 32'd6;
        snap("md_flush", 1'b0);
        md = 1'b0; flush = 1'b0;
        snap("md_flush_after", 1'b0);
        do_mt(1'b1, 32'hDEAD_BEEF, 1'b1);
        snap("mt_flush", 1'b0);

        do_md(MDU_MULT, 32'h0001_2345, 32'h0000_0777, "mult_flush3", 1'b0, 2);
        do_md(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, -1);

        // reset lands on edge 4 of a div: busy for 4 cycles, HI/LO cleared
        w.is_snap = 1'b0; w.name = "reset_abort"; w.hi = '0; w.lo = '0;
        w.lat = 4; w.busy_e = 1'b0; w.start_e = 1'b0;
        want_q.push_back(w);
        md = 1'b1; MDU_op = MDU_DIV; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        md = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        ref_hi = '0;
        ref_lo = '0;
        do_md(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom % 6;
            if (sel < 4) begin
                op = ops[$urandom % 4];
                ra = $urandom;
                rb = $urandom;
                case ($urandom % 8)
                    0: rb = '0;
                    1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                    2: rb = $urandom % 16;
                    default: ;
                endcase
                do_md(op, ra, rb, "rand_md", 1'($urandom % 2), -1);
            end else if (sel == 4) begin
                do_mt(1'($urandom % 2), $urandom, 1'($urandom % 3 == 0));
                snap("rand_mt", 1'b0);
            end else begin
                md = 1'b1; flush = 1'b1; MDU_op = ops[$urandom % 4];
                A = $urandom; B = $urandom;
                snap("rand_md_flush", 1'b0);
                md = 1'b0; flush = 1'b0;
            end
            repeat ($urandom % 3) begin
                @(posedge clk); #1;
            end
        end

        snap("final", 1'b0);
        for (int k = 0; k < 50 && want_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("queue_drained", 32'(want_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
